// File: rtl/uart_pkg.sv
// Shared UART definitions: launch FSM state type and byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Simple dual-port byte array: synchronous write port, combinational read port.
module uart_tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Storage is never reset; stale slots are unreachable once pointers are cleared.
  always_ff @(posedge Clock) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch controller feeding the UART transmitter.
// Start_o/Data_o drive the transmitter's Start_i/Data_i; its Busy_o/Done_o
// come back as Busy_i/Done_i.
// Optional macro UART_TX_FIFO_OVERFLOW_EN adds a sticky Overflow_o flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Write_i,
  input  logic [BYTE_W-1:0] Data_i,
  output logic              Full_o,
  output logic              Empty_o,
  output logic [CW-1:0]     Count_o,
  output logic              Start_o,
  output logic [BYTE_W-1:0] Data_o,
  input  logic              Busy_i,
  input  logic              Done_i
`ifdef UART_TX_FIFO_OVERFLOW_EN
  ,
  output logic              Overflow_o
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  tx_state_e         state_q, state_d;
  logic              start_q, start_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [BYTE_W-1:0] rd_data;
  logic              full, empty, write_ok, pop;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic              overflow_q, overflow_d;
`endif

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign Full_o  = full;
  assign Empty_o = empty;
  assign Count_o = count_q;
  assign Start_o = start_q;
  assign Data_o  = data_q;

  uart_tx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .Clock   (Clock),
    .we_i    (write_ok),
    .waddr_i (wr_q),
    .wdata_i (Data_i),
    .raddr_i (rd_q),
    .rdata_o (rd_data)
  );

  // Next-state for pointers, occupancy and launch FSM; a full FIFO drops writes even when popping.
  always_comb begin
    write_ok = Write_i && !full;
    pop      = (state_q == IDLE) && !empty && !Busy_i;
    wr_d     = write_ok ? wr_q + PW'(1) : wr_q;
    rd_d     = pop ? rd_q + PW'(1) : rd_q;
    count_d  = count_q;
    if (write_ok && !pop) count_d = count_q + CW'(1);
    else if (pop && !write_ok) count_d = count_q - CW'(1);
    start_d  = pop;
    data_d   = pop ? rd_data : data_q;
    state_d  = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = WAIT;
      WAIT:    if (Done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_FIFO_OVERFLOW_EN
    overflow_d = overflow_q || (Write_i && full);
`endif
  end

  // All control state registers together; active-low asynchronous reset clears everything but storage.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      start_q    <= 1'b0;
      data_q     <= '0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      state_q    <= state_d;
      start_q    <= start_d;
      data_q     <= data_d;
`ifdef UART_TX_FIFO_OVERFLOW_EN
      overflow_q <= overflow_d;
`endif
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  assign Overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (DEPTH=4); expectations are hand-computed.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clock;
  logic          Reset;
  logic          Write_i;
  logic [7:0]    Data_i;
  logic          Full_o;
  logic          Empty_o;
  logic [CW-1:0] Count_o;
  logic          Start_o;
  logic [7:0]    Data_o;
  logic          Busy_i;
  logic          Done_i;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic          Overflow_o;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] model_q [$];

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Write_i (Write_i),
    .Data_i  (Data_i),
    .Full_o  (Full_o),
    .Empty_o (Empty_o),
    .Count_o (Count_o),
    .Start_o (Start_o),
    .Data_o  (Data_o),
    .Busy_i  (Busy_i),
    .Done_i  (Done_i)
`ifdef UART_TX_FIFO_OVERFLOW_EN
    ,
    .Overflow_o (Overflow_o)
`endif
  );

  // Free-running clock, period 10
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic          wr;
    logic [7:0]    din;
    logic          busy;
    logic          done;
    logic          exp_start;
    logic [7:0]    exp_data;
    logic [CW-1:0] exp_count;
    logic          exp_full;
    logic          exp_empty;
  } vec_t;

  vec_t vecs [14];

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, settle 1 time unit past it
  task automatic apply_stimulus(input logic wr, input logic [7:0] din, input logic busy, input logic done);
    Write_i = wr;
    Data_i  = din;
    Busy_i  = busy;
    Done_i  = done;
    @(posedge Clock);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic [CW-1:0] cnt, input logic full, input logic empty);
    check_output({tag, ".count"}, 8'(Count_o), 8'(cnt));
    check_output({tag, ".full"},  8'(Full_o),  8'(full));
    check_output({tag, ".empty"}, 8'(Empty_o), 8'(empty));
  endtask

  task automatic write_byte(input logic [7:0] b, input logic busy);
    apply_stimulus(1'b1, b, busy, 1'b0);
    model_q.push_back(b);
  endtask

  // Wait (bounded) for one launch, check its byte against the model, then pulse Done_i
  task automatic drain_one(input string tag);
    logic       seen;
    logic [7:0] exp;
    seen = 1'b0;
    exp  = model_q.pop_front();
    for (int i = 0; i < 8 && !seen; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
      if (Start_o) seen = 1'b1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s.launch_timeout: no Start_o, expected byte %0h", tag, exp);
    end else begin
      check_output({tag, ".data"}, Data_o, exp);
      apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
      check_output({tag, ".start_one_cycle"}, 8'(Start_o), 8'h00);
    end
  endtask

  task automatic drain_all(input string tag);
    while (model_q.size() != 0) drain_one(tag);
    check_flags({tag, ".drained"}, '0, 1'b0, 1'b1);
  endtask

  task automatic pulse_reset();
    #1;
    Reset = 1'b0;
    #3;
    Reset = 1'b1;
    model_q.delete();
  endtask

  initial begin
    // Reset then a single byte; then three bytes held back by Busy_i and released one by one
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 8'hA5, 3'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 3'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 3'd2, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 3'd0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h03, 3'd0, 1'b0, 1'b1};

    Reset   = 1'b0;
    Write_i = 1'b0;
    Data_i  = 8'h00;
    Busy_i  = 1'b0;
    Done_i  = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_flags("reset", '0, 1'b0, 1'b1);
    check_output("reset.start", 8'(Start_o), 8'h00);
    check_output("reset.data", Data_o, 8'h00);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check_output("reset.overflow", 8'(Overflow_o), 8'h00);
`endif
    Reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].wr, vecs[i].din, vecs[i].busy, vecs[i].done);
      check_output($sformatf("vec%0d.start", i), 8'(Start_o), 8'(vecs[i].exp_start));
      check_output($sformatf("vec%0d.data", i), Data_o, vecs[i].exp_data);
      check_flags($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_full, vecs[i].exp_empty);
    end

    // Fill DEPTH=4 while busy; 5th write dropped; a write while full with a pop is also dropped
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
      check_flags($sformatf("fill%0d", i), CW'(i + 1), (i == 3), 1'b0);
    end
    apply_stimulus(1'b1, 8'h14, 1'b1, 1'b0);
    check_flags("fill.drop", 3'd4, 1'b1, 1'b0);
    check_output("fill.no_start", 8'(Start_o), 8'h00);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check_output("fill.overflow", 8'(Overflow_o), 8'h01);
`endif
    apply_stimulus(1'b1, 8'h99, 1'b0, 1'b0);
    check_output("full_pop.start", 8'(Start_o), 8'h01);
    check_output("full_pop.data", Data_o, 8'h10);
    check_flags("full_pop", 3'd3, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    model_q = '{8'h11, 8'h12, 8'h13};
    drain_all("full_drain");
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check_output("overflow.sticky", 8'(Overflow_o), 8'h01);
`endif

    // Write and launch on the same edge with count=2
    write_byte(8'h20, 1'b1);
    write_byte(8'h21, 1'b1);
    check_flags("same.pre", 3'd2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'h22, 1'b0, 1'b0);
    model_q.push_back(8'h22);
    void'(model_q.pop_front());
    check_output("same.start", 8'(Start_o), 8'h01);
    check_output("same.data", Data_o, 8'h20);
    check_flags("same.post", 3'd2, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    drain_all("same_drain");

    // Reset while in WAIT with bytes still queued
    write_byte(8'h30, 1'b1);
    write_byte(8'h31, 1'b1);
    write_byte(8'h32, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("midwait.start", 8'(Start_o), 8'h01);
    check_output("midwait.data", Data_o, 8'h30);
    pulse_reset();
    check_flags("post_reset", '0, 1'b0, 1'b1);
    check_output("post_reset.start", 8'(Start_o), 8'h00);
    check_output("post_reset.data", Data_o, 8'h00);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    check_output("post_reset.overflow", 8'(Overflow_o), 8'h00);
`endif
    apply_stimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    check_flags("post_reset.write", 3'd1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
    check_output("post_reset.launch", 8'(Start_o), 8'h01);
    check_output("post_reset.launch_data", Data_o, 8'h5A);
    apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // 2*DEPTH+3 bytes in bursts of up to 3 to walk the pointers around the ring
    for (int n = 0; n < 2 * DEPTH + 3; n += 3) begin
      for (int k = n; k < n + 3 && k < 2 * DEPTH + 3; k++) write_byte(8'h60 + 8'(k), 1'b1);
      check_flags($sformatf("wrap%0d.burst", n), CW'(model_q.size()), 1'b0, 1'b0);
      drain_all($sformatf("wrap%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
